// File: rtl/dcache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_arb_pkg
// Description : Shared types for the dcache port arbiter (FSM state encoding
//               and the registered dcache request bundle).
// Revision    : 1.0
// ============================================================================
package dcache_arb_pkg;

    localparam int unsigned DC_ADDR_W = 32;
    localparam int unsigned DC_DATA_W = 32;
    localparam int unsigned DC_SEL_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOAD  = 2'd1,
        ARB_STORE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DC_ADDR_W-1:0] addr;
        logic [DC_DATA_W-1:0] wdata;
        logic [DC_SEL_W-1:0]  sel_byte;
        logic                 w_en;
    } dcache_req_t;

endpackage
`default_nettype wire

// File: rtl/dcache_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_counter
// Description : Saturating up-counter with synchronous clear; flags when the
//               count has reached LIMIT.
// Revision    : 1.0
// ============================================================================
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment so a store grant always restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcache_port_arbiter
// Description : Shares the single dcache port between LSU loads and store
//               buffer drains; load priority with store urgency overrides.
// Revision    : 1.0
// ============================================================================
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_SEL_WIDTH = 4,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     lsu2arb_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] lsu2arb_sel_byte,
    input  logic                      lsu2arb_req,
    output logic [DATA_WIDTH-1:0]     arb2lsu_rdata,
    output logic                      arb2lsu_ack,
    input  logic                      lsu2arb_fence,
    output logic                      arb2lsu_fence_done,

    input  logic [ADDR_WIDTH-1:0]     stb2arb_addr,
    input  logic [DATA_WIDTH-1:0]     stb2arb_wdata,
    input  logic [BYTE_SEL_WIDTH-1:0] stb2arb_sel_byte,
    input  logic                      stb2arb_req,
    input  logic                      stb2arb_full,
    input  logic                      stb2arb_empty,
    input  logic                      stb2arb_hit,
    output logic                      arb2stb_ack,

    output logic [ADDR_WIDTH-1:0]     arb2dcache_addr,
    output logic [DATA_WIDTH-1:0]     arb2dcache_wdata,
    output logic [BYTE_SEL_WIDTH-1:0] arb2dcache_sel_byte,
    output logic                      arb2dcache_w_en,
    output logic                      arb2dcache_req,
    input  logic [DATA_WIDTH-1:0]     dcache2arb_rdata,
    input  logic                      dcache2arb_ack
);

    arb_state_e  r_state;
    arb_state_e  w_next_state;
    dcache_req_t r_txn;
    logic        r_dcache_req;

    logic w_starved;
    logic w_store_urgent;
    logic w_load_ok;
    logic w_grant_load;
    logic w_grant_store;
    logic w_busy_ack;

    assign w_store_urgent = stb2arb_req & (stb2arb_full | lsu2arb_fence |
                                           (lsu2arb_req & stb2arb_hit) | w_starved);
    assign w_load_ok      = lsu2arb_req & ~stb2arb_hit & ~lsu2arb_fence;
    assign w_busy_ack     = dcache2arb_ack & (r_state != ARB_IDLE);

    always_comb begin
        w_next_state  = r_state;
        w_grant_load  = 1'b0;
        w_grant_store = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_store_urgent) begin
                    w_next_state  = ARB_STORE;
                    w_grant_store = 1'b1;
                end else if (w_load_ok) begin
                    w_next_state  = ARB_LOAD;
                    w_grant_load  = 1'b1;
                end else if (stb2arb_req) begin
                    w_next_state  = ARB_STORE;
                    w_grant_store = 1'b1;
                end
            end
            ARB_LOAD, ARB_STORE: begin
                if (dcache2arb_ack) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // A load only counts toward starvation when a store was actually waiting.
    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_grant_load & stb2arb_req),
        .i_clr (w_grant_store),
        .o_sat (w_starved)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_txn        <= '0;
            r_dcache_req <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_store) begin
                r_txn.addr     <= DC_ADDR_W'(stb2arb_addr);
                r_txn.wdata    <= DC_DATA_W'(stb2arb_wdata);
                r_txn.sel_byte <= DC_SEL_W'(stb2arb_sel_byte);
                r_txn.w_en     <= 1'b1;
                r_dcache_req   <= 1'b1;
            end else if (w_grant_load) begin
                r_txn.addr     <= DC_ADDR_W'(lsu2arb_addr);
                r_txn.wdata    <= '0;
                r_txn.sel_byte <= DC_SEL_W'(lsu2arb_sel_byte);
                r_txn.w_en     <= 1'b0;
                r_dcache_req   <= 1'b1;
            end else if (w_busy_ack) begin
                r_txn.w_en     <= 1'b0;
                r_dcache_req   <= 1'b0;
            end
        end
    end

    assign arb2dcache_addr     = ADDR_WIDTH'(r_txn.addr);
    assign arb2dcache_wdata    = DATA_WIDTH'(r_txn.wdata);
    assign arb2dcache_sel_byte = BYTE_SEL_WIDTH'(r_txn.sel_byte);
    assign arb2dcache_w_en     = r_txn.w_en;
    assign arb2dcache_req      = r_dcache_req;

    assign arb2lsu_ack        = dcache2arb_ack & (r_state == ARB_LOAD);
    assign arb2stb_ack        = dcache2arb_ack & (r_state == ARB_STORE);
    assign arb2lsu_rdata      = arb2lsu_ack ? dcache2arb_rdata : '0;
    assign arb2lsu_fence_done = lsu2arb_fence & stb2arb_empty &
                                (r_state == ARB_IDLE) & ~stb2arb_req;

endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dcache_port_arbiter
// Description : Scoreboard bench: requester/dcache models plus a monitor that
//               checks every dcache transaction against an expected queue.
// Revision    : 1.0
// ============================================================================
module tb_dcache_port_arbiter;

    localparam int K_REQ = 0, K_WEN = 1, K_FDONE = 2, K_STB = 3, K_LSU = 4,
                   K_ADDR = 5, K_WDATA = 6, K_SEL = 7, K_PEND = 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        w;
    } txn_t;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] v;
    } probe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lsu2arb_addr = '0;
    logic [3:0]  lsu2arb_sel_byte = '0;
    logic        lsu2arb_req = 1'b0;
    logic [31:0] arb2lsu_rdata;
    logic        arb2lsu_ack;
    logic        lsu2arb_fence = 1'b0;
    logic        arb2lsu_fence_done;
    logic [31:0] stb2arb_addr = '0;
    logic [31:0] stb2arb_wdata = '0;
    logic [3:0]  stb2arb_sel_byte = '0;
    logic        stb2arb_req = 1'b0;
    logic        stb2arb_full = 1'b0;
    logic        stb2arb_empty = 1'b1;
    logic        stb2arb_hit = 1'b0;
    logic        arb2stb_ack;
    logic [31:0] arb2dcache_addr;
    logic [31:0] arb2dcache_wdata;
    logic [3:0]  arb2dcache_sel_byte;
    logic        arb2dcache_w_en;
    logic        arb2dcache_req;
    logic [31:0] dcache2arb_rdata = '0;
    logic        dcache2arb_ack = 1'b0;

    dcache_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_SEL_WIDTH(4), .STARVE_LIMIT(4)
    ) u_dut (
        .clk(clk), .rst(rst),
        .lsu2arb_addr(lsu2arb_addr), .lsu2arb_sel_byte(lsu2arb_sel_byte),
        .lsu2arb_req(lsu2arb_req), .arb2lsu_rdata(arb2lsu_rdata),
        .arb2lsu_ack(arb2lsu_ack), .lsu2arb_fence(lsu2arb_fence),
        .arb2lsu_fence_done(arb2lsu_fence_done),
        .stb2arb_addr(stb2arb_addr), .stb2arb_wdata(stb2arb_wdata),
        .stb2arb_sel_byte(stb2arb_sel_byte), .stb2arb_req(stb2arb_req),
        .stb2arb_full(stb2arb_full), .stb2arb_empty(stb2arb_empty),
        .stb2arb_hit(stb2arb_hit), .arb2stb_ack(arb2stb_ack),
        .arb2dcache_addr(arb2dcache_addr), .arb2dcache_wdata(arb2dcache_wdata),
        .arb2dcache_sel_byte(arb2dcache_sel_byte), .arb2dcache_w_en(arb2dcache_w_en),
        .arb2dcache_req(arb2dcache_req), .dcache2arb_rdata(dcache2arb_rdata),
        .dcache2arb_ack(dcache2arb_ack)
    );

    always #5 clk = ~clk;

    txn_t   exp_q[$];
    txn_t   ld_q[$];
    txn_t   st_q[$];
    probe_t pr_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   ld_done = 0;
    int   st_done = 0;
    int   ld_pop = 0;
    int   st_pop = 0;
    int   lat = 0;
    int   wait_cnt = 0;
    logic stray = 1'b0;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // dcache model + monitor: ack after `lat` req cycles, then score the transaction.
    always @(negedge clk) begin
        txn_t e;
        logic txn;
        cyc = cyc + 1;
        dcache2arb_ack   = 1'b0;
        dcache2arb_rdata = '0;
        if (arb2dcache_req === 1'b1) begin
            if (wait_cnt >= lat) begin
                dcache2arb_ack   = 1'b1;
                dcache2arb_rdata = rd_model(arb2dcache_addr);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (stray) begin
                dcache2arb_ack   = 1'b1;
                dcache2arb_rdata = 32'h1234_5678;
            end
        end
        #1;
        txn = dcache2arb_ack && (arb2dcache_req === 1'b1);
        if (txn) begin
            if (exp_q.size() == 0) begin
                chk("txn_expected", 32'(exp_q.size()), 32'd1);
                if (arb2dcache_w_en === 1'b1) st_done++; else ld_done++;
            end else begin
                e = exp_q.pop_front();
                chk("addr", arb2dcache_addr, e.addr);
                chk("wdata", arb2dcache_wdata, e.wdata);
                chk("sel", 32'(arb2dcache_sel_byte), 32'(e.sel));
                chk("w_en", 32'(arb2dcache_w_en), 32'(e.w));
                chk("lsu_ack", 32'(arb2lsu_ack), 32'(!e.w));
                chk("stb_ack", 32'(arb2stb_ack), 32'(e.w));
                chk("lsu_rdata", arb2lsu_rdata, e.w ? 32'h0 : rd_model(e.addr));
                if (e.w) st_done++; else ld_done++;
            end
        end else begin
            chk("idle_lsu_ack", 32'(arb2lsu_ack), 32'h0);
            chk("idle_stb_ack", 32'(arb2stb_ack), 32'h0);
            chk("idle_rdata", arb2lsu_rdata, 32'h0);
        end
        for (int i = pr_q.size() - 1; i >= 0; i--) begin
            if (pr_q[i].due == cyc) begin
                case (pr_q[i].kind)
                    K_REQ:   chk("p_req", 32'(arb2dcache_req), pr_q[i].v);
                    K_WEN:   chk("p_w_en", 32'(arb2dcache_w_en), pr_q[i].v);
                    K_FDONE: chk("p_fence_done", 32'(arb2lsu_fence_done), pr_q[i].v);
                    K_STB:   chk("p_stb_ack", 32'(arb2stb_ack), pr_q[i].v);
                    K_LSU:   chk("p_lsu_ack", 32'(arb2lsu_ack), pr_q[i].v);
                    K_ADDR:  chk("p_addr", arb2dcache_addr, pr_q[i].v);
                    K_WDATA: chk("p_wdata", arb2dcache_wdata, pr_q[i].v);
                    K_SEL:   chk("p_sel", 32'(arb2dcache_sel_byte), pr_q[i].v);
                    default: chk("p_pending", 32'(exp_q.size() + ld_q.size() + st_q.size()), pr_q[i].v);
                endcase
                pr_q.delete(i);
            end
        end
    end

    // Requester models: hold each request until its transaction completes.
    always @(posedge clk) begin
        logic m;
        #2;
        while (ld_pop < ld_done) begin
            if (ld_q.size() > 0) ld_q.delete(0);
            ld_pop++;
        end
        while (st_pop < st_done) begin
            if (st_q.size() > 0) st_q.delete(0);
            st_pop++;
        end
        lsu2arb_req      = (ld_q.size() > 0);
        lsu2arb_addr     = (ld_q.size() > 0) ? ld_q[0].addr : 32'h0;
        lsu2arb_sel_byte = (ld_q.size() > 0) ? ld_q[0].sel : 4'h0;
        stb2arb_req      = (st_q.size() > 0);
        stb2arb_empty    = (st_q.size() == 0);
        stb2arb_addr     = (st_q.size() > 0) ? st_q[0].addr : 32'h0;
        stb2arb_wdata    = (st_q.size() > 0) ? st_q[0].wdata : 32'h0;
        stb2arb_sel_byte = (st_q.size() > 0) ? st_q[0].sel : 4'h0;
        m = 1'b0;
        foreach (st_q[i]) if (lsu2arb_req && st_q[i].addr == lsu2arb_addr) m = 1'b1;
        stb2arb_hit = m;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic probe(input int d, input int k, input logic [31:0] v);
        pr_q.push_back('{due: cyc + d, kind: k, v: v});
    endtask

    task automatic ld(input logic [31:0] a, input logic [3:0] s);
        ld_q.push_back('{addr: a, wdata: 32'h0, sel: s, w: 1'b0});
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_q.push_back('{addr: a, wdata: d, sel: s, w: 1'b1});
    endtask

    task automatic exp_ld(input logic [31:0] a, input logic [3:0] s);
        exp_q.push_back('{addr: a, wdata: 32'h0, sel: s, w: 1'b0});
    endtask

    task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{addr: a, wdata: d, sel: s, w: 1'b1});
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && ld_q.size() == 0 && st_q.size() == 0) break;
            tick(1);
        end
        probe(1, K_PEND, 32'h0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        // Reset values
        probe(1, K_REQ, 0); probe(1, K_WEN, 0); probe(1, K_ADDR, 0);
        probe(1, K_WDATA, 0); probe(1, K_SEL, 0); probe(1, K_FDONE, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Single load, dcache acks one cycle after req
        lat = 1;
        ld(32'h1000, 4'hF); exp_ld(32'h1000, 4'hF);
        probe(1, K_REQ, 0); probe(2, K_REQ, 1); probe(2, K_WEN, 0);
        probe(2, K_ADDR, 32'h1000); probe(3, K_LSU, 1); probe(4, K_REQ, 0);
        drain();

        // Single store, minimum-length transaction
        lat = 0;
        st(32'h1004, 32'hCCCC_DDDD, 4'hF); exp_st(32'h1004, 32'hCCCC_DDDD, 4'hF);
        probe(2, K_WEN, 1); probe(2, K_WDATA, 32'hCCCC_DDDD);
        probe(2, K_STB, 1); probe(3, K_REQ, 0);
        drain();

        // Contention: starvation forces a store after every 4 loads
        for (int i = 0; i < 9; i++) ld(32'h100 + 32'(i * 4), 4'h3);
        st(32'h800, 32'h5555_0000, 4'hC);
        st(32'h804, 32'h5555_0001, 4'hF);
        for (int i = 0; i < 4; i++) exp_ld(32'h100 + 32'(i * 4), 4'h3);
        exp_st(32'h800, 32'h5555_0000, 4'hC);
        for (int i = 4; i < 8; i++) exp_ld(32'h100 + 32'(i * 4), 4'h3);
        exp_st(32'h804, 32'h5555_0001, 4'hF);
        exp_ld(32'h120, 4'h3);
        drain();

        // Full store buffer overrides load priority
        stb2arb_full = 1'b1;
        ld(32'h4000, 4'h1); st(32'h4100, 32'h1111_2222, 4'h3);
        exp_st(32'h4100, 32'h1111_2222, 4'h3); exp_ld(32'h4000, 4'h1);
        drain();
        stb2arb_full = 1'b0;

        // RAW hazard: matching store drains before the load
        st(32'h3000, 32'hAAAA_0001, 4'hF); st(32'h2000, 32'hAAAA_0002, 4'hF);
        ld(32'h2000, 4'h1);
        exp_st(32'h3000, 32'hAAAA_0001, 4'hF); exp_st(32'h2000, 32'hAAAA_0002, 4'hF);
        exp_ld(32'h2000, 4'h1);
        drain();

        // Fence: stores drain, fence_done rises, load withheld until fence drops
        lsu2arb_fence = 1'b1;
        st(32'h6000, 32'hF00D_0000, 4'hF); st(32'h6004, 32'hF00D_0004, 4'h8);
        ld(32'h7000, 4'hF);
        exp_st(32'h6000, 32'hF00D_0000, 4'hF); exp_st(32'h6004, 32'hF00D_0004, 4'h8);
        probe(3, K_FDONE, 0); probe(5, K_FDONE, 1);
        probe(7, K_REQ, 0); probe(7, K_FDONE, 1);
        tick(7);
        lsu2arb_fence = 1'b0;
        exp_ld(32'h7000, 4'hF);
        probe(1, K_FDONE, 0);
        drain();

        // Stray dcache ack while idle produces no requester ack
        stray = 1'b1;
        probe(1, K_REQ, 0);
        tick(2);
        stray = 1'b0;
        tick(1);

        // Reset during a store: request aborted, no ack, store retried afterwards
        lat = 6;
        st(32'h5000, 32'hABCD_0123, 4'hC); exp_st(32'h5000, 32'hABCD_0123, 4'hC);
        probe(2, K_REQ, 1); probe(2, K_WEN, 1);
        tick(3);
        rst = 1'b1;
        probe(1, K_REQ, 0); probe(1, K_STB, 0); probe(1, K_WEN, 0);
        tick(1);
        rst = 1'b0;
        lat = 0;
        drain();

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
